// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall FSM, taken-branch flush, EX operand
// forwarding selects and a saturating stall-cycle performance counter.
module hazard_unit #(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_branch_taken,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              mem_reg_write,
  input  logic              wb_reg_write,
  input  logic              perf_clr,
  output logic              stall,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic {IDLE, HOLD} state_t;

  // The hazard cycle itself is the first stall cycle, so HOLD covers the rest.
  localparam logic [3:0] HOLD_INIT = 4'(LOAD_STALL - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic             hz;

  assign hz = ex_mem_read && (ex_rd != '0) &&
              ((id_rs1_used && (id_rs1 == ex_rd)) ||
               (id_rs2_used && (id_rs2 == ex_rd)));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall      = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    if (ex_branch_taken) begin
      // A redirect makes the stalled instruction in ID dead anyway.
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      state_d    = IDLE;
      cnt_d      = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          stall      = hz;
          flush_idex = hz;
          if (hz && (LOAD_STALL > 1)) begin
            state_d = HOLD;
            cnt_d   = HOLD_INIT;
          end
        end
        HOLD: begin
          stall      = 1'b1;
          flush_idex = 1'b1;
          cnt_d      = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (perf_clr)
      stall_cycles_d = '0;
    else if (stall && !(&stall_cycles_q))
      stall_cycles_d = stall_cycles_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

  // MEM holds the younger result, so it wins over WB.
  always_comb begin
    fwd_a = 2'b00;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs1))
      fwd_a = 2'b10;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs1))
      fwd_a = 2'b01;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs2))
      fwd_b = 2'b10;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs2))
      fwd_b = 2'b01;
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: one LOAD_STALL=1 instance and one
// LOAD_STALL=3 instance with a narrow counter, sharing the same stimulus.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_rs1_used, id_rs2_used, ex_mem_read, ex_branch_taken;
  logic       mem_reg_write, wb_reg_write, perf_clr;

  logic        stall1, flush_ifid1, flush_idex1;
  logic [1:0]  fwd_a1, fwd_b1;
  logic [15:0] stall_cycles1;
  logic        stall3, flush_ifid3, flush_idex3;
  logic [1:0]  fwd_a3, fwd_b3;
  logic [3:0]  stall_cycles3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_unit #(.REG_AW(5), .LOAD_STALL(1), .CNT_W(16)) u_ls1 (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write), .perf_clr(perf_clr),
    .stall(stall1), .flush_ifid(flush_ifid1), .flush_idex(flush_idex1),
    .fwd_a(fwd_a1), .fwd_b(fwd_b1), .stall_cycles(stall_cycles1)
  );

  hazard_unit #(.REG_AW(5), .LOAD_STALL(3), .CNT_W(4)) u_ls3 (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write), .perf_clr(perf_clr),
    .stall(stall3), .flush_ifid(flush_ifid3), .flush_idex(flush_idex3),
    .fwd_a(fwd_a3), .fwd_b(fwd_b3), .stall_cycles(stall_cycles3)
  );

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] xrs1, xrs2, xrd;
    logic       mr, br;
    logic [4:0] mrd, wrd;
    logic       mw, ww;
    logic       e_stall, e_fifid, e_fidex;
    logic [1:0] e_fa, e_fb;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
    ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_mem_read = 0; ex_branch_taken = 0;
    mem_rd = '0; wb_rd = '0; mem_reg_write = 0; wb_reg_write = 0; perf_clr = 0;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0]  = '{0,0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0,0, 2'b00,2'b00};
    vecs[1]  = '{5,0,1,0, 0,0,5, 1,0, 0,0,0,0, 1,0,1, 2'b00,2'b00};
    vecs[2]  = '{0,9,0,1, 0,0,9, 1,0, 0,0,0,0, 1,0,1, 2'b00,2'b00};
    vecs[3]  = '{0,0,1,0, 0,0,0, 1,0, 0,0,0,0, 0,0,0, 2'b00,2'b00};
    vecs[4]  = '{0,6,0,0, 0,0,6, 1,0, 0,0,0,0, 0,0,0, 2'b00,2'b00};
    vecs[5]  = '{5,0,1,0, 0,0,5, 0,0, 0,0,0,0, 0,0,0, 2'b00,2'b00};
    vecs[6]  = '{0,0,0,0, 0,0,0, 0,1, 0,0,0,0, 0,1,1, 2'b00,2'b00};
    vecs[7]  = '{5,0,1,0, 0,0,5, 1,1, 0,0,0,0, 0,1,1, 2'b00,2'b00};
    vecs[8]  = '{0,0,0,0, 7,0,0, 0,0, 7,7,1,1, 0,0,0, 2'b10,2'b00};
    vecs[9]  = '{0,0,0,0, 7,0,0, 0,0, 7,7,0,1, 0,0,0, 2'b01,2'b00};
    vecs[10] = '{0,0,0,0, 0,0,0, 0,0, 0,0,1,1, 0,0,0, 2'b00,2'b00};
    vecs[11] = '{0,0,0,0, 4,3,0, 0,0, 3,4,1,1, 0,0,0, 2'b01,2'b10};
    vecs[12] = '{0,0,0,0, 0,12,0, 0,0, 12,12,0,1, 0,0,0, 2'b00,2'b01};
    vecs[13] = '{5,0,1,0, 8,0,5, 1,1, 8,0,1,0, 0,1,1, 2'b10,2'b00};
    vecs[14] = '{0,0,0,0, 7,0,0, 0,0, 0,7,0,0, 0,0,0, 2'b00,2'b00};

    // Reset state with all inputs low
    clear_inputs();
    @(negedge clk);
    chk("rst_stall1", stall1, 0);
    chk("rst_fifid1", flush_ifid1, 0);
    chk("rst_fidex1", flush_idex1, 0);
    chk("rst_fwd1", {fwd_a1, fwd_b1}, 0);
    chk("rst_cnt1", stall_cycles1, 0);
    chk("rst_stall3", stall3, 0);
    chk("rst_cnt3", stall_cycles3, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("post_rst_stall3", stall3, 0);
    $display("reset: stall1=%0b stall3=%0b cnt1=%0d cnt3=%0d", stall1, stall3, stall_cycles1, stall_cycles3);

    // Combinational vectors on the single-cycle-stall instance (always IDLE)
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      id_rs1_used = vecs[i].u1; id_rs2_used = vecs[i].u2;
      ex_rs1 = vecs[i].xrs1; ex_rs2 = vecs[i].xrs2; ex_rd = vecs[i].xrd;
      ex_mem_read = vecs[i].mr; ex_branch_taken = vecs[i].br;
      mem_rd = vecs[i].mrd; wb_rd = vecs[i].wrd;
      mem_reg_write = vecs[i].mw; wb_reg_write = vecs[i].ww;
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), stall1, vecs[i].e_stall);
      chk($sformatf("v%0d_fifid", i), flush_ifid1, vecs[i].e_fifid);
      chk($sformatf("v%0d_fidex", i), flush_idex1, vecs[i].e_fidex);
      chk($sformatf("v%0d_fwd_a", i), fwd_a1, vecs[i].e_fa);
      chk($sformatf("v%0d_fwd_b", i), fwd_b1, vecs[i].e_fb);
      $display("vec %0d: stall=%0b fifid=%0b fidex=%0b fwd_a=%b fwd_b=%b", i,
               stall1, flush_ifid1, flush_idex1, fwd_a1, fwd_b1);
    end

    // One-cycle load-use hazard: 1 stall on LS1, 3 stalls on LS3
    do_reset();
    set_load_use();
    @(negedge clk);
    chk("lu_c0_stall1", stall1, 1);
    chk("lu_c0_fidex1", flush_idex1, 1);
    chk("lu_c0_stall3", stall3, 1);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("lu_c1_stall1", stall1, 0);
    chk("lu_c1_fidex1", flush_idex1, 0);
    chk("lu_c1_cnt1", stall_cycles1, 1);
    chk("lu_c1_stall3", stall3, 1);
    chk("lu_c1_fidex3", flush_idex3, 1);
    next_cycle();
    @(negedge clk);
    chk("lu_c2_stall3", stall3, 1);
    next_cycle();
    @(negedge clk);
    chk("lu_c3_stall3", stall3, 0);
    chk("lu_c3_cnt3", stall_cycles3, 3);
    chk("lu_c3_cnt1", stall_cycles1, 1);
    $display("load-use: cnt1=%0d cnt3=%0d", stall_cycles1, stall_cycles3);

    // Taken branch in the second HOLD cycle aborts the stall
    do_reset();
    set_load_use();
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("br_hold1_stall3", stall3, 1);
    next_cycle();
    ex_branch_taken = 1;
    @(negedge clk);
    chk("br_hold2_stall3", stall3, 0);
    chk("br_hold2_fifid3", flush_ifid3, 1);
    chk("br_hold2_fidex3", flush_idex3, 1);
    next_cycle();
    ex_branch_taken = 0;
    @(negedge clk);
    chk("br_after_stall3", stall3, 0);
    chk("br_after_fidex3", flush_idex3, 0);
    chk("br_after_fifid3", flush_ifid3, 0);
    $display("branch abort: stall3=%0b cnt3=%0d", stall3, stall_cycles3);

    // Asynchronous reset in the middle of HOLD
    do_reset();
    set_load_use();
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("ar_hold_stall3", stall3, 1);
    #1 rst = 1;
    #1;
    chk("ar_async_stall3", stall3, 0);
    chk("ar_async_cnt3", stall_cycles3, 0);
    next_cycle();
    rst = 0;
    @(negedge clk);
    chk("ar_release_stall3", stall3, 0);
    next_cycle();
    @(negedge clk);
    chk("ar_release2_stall3", stall3, 0);
    $display("async reset: stall3=%0b cnt3=%0d", stall3, stall_cycles3);

    // Counter saturation on the 4-bit instance, then clear wins over increment
    do_reset();
    set_load_use();
    repeat (14) @(posedge clk);
    @(negedge clk);
    chk("sat_cnt3_14", stall_cycles3, 14);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sat_cnt3_hold", stall_cycles3, 15);
    chk("sat_stall3", stall3, 1);
    perf_clr = 1;
    @(posedge clk); #1;
    perf_clr = 0;
    clear_inputs();
    @(negedge clk);
    chk("sat_clr_cnt3", stall_cycles3, 0);
    chk("sat_clr_cnt1", stall_cycles1, 0);
    $display("saturate/clear: cnt3=%0d cnt1=%0d", stall_cycles3, stall_cycles1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-002 The block SHALL have parameter LOAD_STALL, default 1, legal 1..15, meaning the number of stall cycles per load-use hazard.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the width of the stall performance counter.
REQ-004 The block SHALL use one clock, and reset SHALL be asynchronous and active-high; ports are listed below as name, direction, width, meaning.
REQ-005 clk, in, 1: rising-edge clock.
REQ-006 rst, in, 1: asynchronous active-high reset.
REQ-007 id_rs1 / id_rs2, in, REG_AW: source registers of the instruction in ID.
REQ-008 id_rs1_used / id_rs2_used, in, 1: ID instruction actually reads that source.
REQ-009 ex_rs1 / ex_rs2, in, REG_AW: source registers of the instruction in EX.
REQ-010 ex_rd, in, REG_AW: destination register in EX.
REQ-011 ex_mem_read, in, 1: EX instruction is a load.
REQ-012 ex_branch_taken, in, 1: branch or jump resolved taken in EX.
REQ-013 mem_rd / wb_rd, in, REG_AW: destination registers in MEM and WB.
REQ-014 mem_reg_write / wb_reg_write, in, 1: MEM / WB instruction writes its rd.
REQ-015 perf_clr, in, 1: synchronous clear of stall_cycles.
REQ-016 stall, out, 1: hold PC and IF/ID.
REQ-017 flush_ifid, out, 1: zero the IF/ID register.
REQ-018 flush_idex, out, 1: insert a bubble into ID/EX.
REQ-019 fwd_a / fwd_b, out, 2: EX operand select; 00 = register file, 10 = MEM result, 01 = WB result.
REQ-020 stall_cycles, out, CNT_W: saturating count of stalled cycles.

Function
REQ-021 hz SHALL equal ex_mem_read & (ex_rd != 0) & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd)); register 0 SHALL never cause a hazard.
REQ-022 The FSM SHALL have states IDLE and HOLD, plus a 4-bit down-counter cnt.
REQ-023 In IDLE, stall and flush_idex SHALL equal hz combinationally, in the same cycle the hazard is visible.
REQ-024 In IDLE, when hz=1 and LOAD_STALL>1, the FSM SHALL move to HOLD with cnt=LOAD_STALL-1; when LOAD_STALL=1, it SHALL remain in IDLE.
REQ-025 In HOLD, stall=1 and flush_idex=1 regardless of hz; cnt SHALL decrement each cycle, and the FSM SHALL return to IDLE on the cycle after cnt==1.
REQ-026 Total stall per hazard SHALL be exactly LOAD_STALL cycles.
REQ-027 ex_branch_taken=1 SHALL have priority over all other conditions: flush_ifid=1, flush_idex=1, stall=0, and next state IDLE with cnt=0, aborting any HOLD.
REQ-028 Outside a taken branch, flush_ifid SHALL be 0.
REQ-029 fwd_a SHALL be 10 if mem_reg_write & mem_rd!=0 & mem_rd==ex_rs1; else 01 if wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1; else 00. MEM SHALL take priority over WB.
REQ-030 fwd_b SHALL follow the same rule as fwd_a using ex_rs2.
REQ-031 Forwarding SHALL be combinational and independent of stall and flush.
REQ-032 stall_cycles SHALL increment by 1 on each clock edge where stall=1 and SHALL saturate at all-ones.
REQ-033 perf_clr=1 SHALL load stall_cycles with 0 and SHALL take priority over increment.

Reset
REQ-034 rst=1 SHALL immediately force state IDLE, cnt=0, and stall_cycles=0, independent of clk.
REQ-035 With all inputs at 0 during or after reset, all outputs SHALL read 0.
REQ-036 Reset asserted mid-HOLD SHALL drop stall on the same cycle, with no residual stall after release.

Verification
REQ-037 LOAD_STALL=1: ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1 for one cycle -> stall=1 and flush_idex=1 for that cycle only; stall_cycles=1.
REQ-038 LOAD_STALL=3, same stimulus held one cycle and then removed -> stall=1 for exactly 3 consecutive cycles; stall_cycles=3.
REQ-039 ex_rd=0 with id_rs1=0 and ex_mem_read=1 -> stall=0; and with id_rs2=ex_rd but id_rs2_used=0 -> stall=0.
REQ-040 LOAD_STALL=3, ex_branch_taken=1 in the second HOLD cycle -> in that cycle stall=0, flush_ifid=1, flush_idex=1; the next cycle is IDLE with stall=0.
REQ-041 mem_rd=wb_rd=ex_rs1=7 with both write enables set -> fwd_a=10; with mem_reg_write=0 -> fwd_a=01; with ex_rs1=0 -> fwd_a=00.
REQ-042 Force stall_cycles to all-ones minus 1, then stall 3 cycles -> holds all-ones; then perf_clr=1 together with stall=1 -> 0.
